// File: rtl/mux4way_arb.sv
// mux4way_arb: four valid/ready sources merged round-robin into one registered
// output word tagged with the index of the channel it came from.
module mux4way_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             valid2,
  input  logic             valid3,
  output logic             ready0,
  output logic             ready1,
  output logic             ready2,
  output logic             ready3,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       sel
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] out_q;
  logic [1:0]       sel_q;
  logic [1:0]       last_q;

  logic [3:0]       valid_vec;
  logic [3:0]       rot_valid;
  logic [1:0]       start;
  logic [1:0]       offset;
  logic [1:0]       grant_idx;
  logic             any_valid;
  logic             load;
  logic             grant;
  logic [3:0]       ready_vec;
  logic [WIDTH-1:0] grant_data;

  assign valid_vec = {valid3, valid2, valid1, valid0};
  assign out_valid = (state_q == FULL);
  assign load      = (state_q == EMPTY) || (out_valid && out_ready);

  // Search begins one past the last winner; the 2-bit add wraps 3 -> 0.
  assign start = last_q + 2'd1;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rot_valid = valid_vec;
    case (start)
      2'd0: rot_valid = valid_vec;
      2'd1: rot_valid = {valid_vec[0],   valid_vec[3:1]};
      2'd2: rot_valid = {valid_vec[1:0], valid_vec[3:2]};
      2'd3: rot_valid = {valid_vec[2:0], valid_vec[3]};
      default: rot_valid = valid_vec;
    endcase
  end

  // First valid channel in rotated order, then mapped back to its real index.
  always_comb begin
    offset = 2'd0;
    if (rot_valid[0])      offset = 2'd0;
    else if (rot_valid[1]) offset = 2'd1;
    else if (rot_valid[2]) offset = 2'd2;
    else if (rot_valid[3]) offset = 2'd3;
  end

  assign any_valid = |valid_vec;
  assign grant_idx = start + offset;
  assign grant     = load && any_valid;

  // Ready is held low throughout reset even though the state already looks
  // loadable, so no source sees a handshake that the register will drop.
  assign ready_vec = (grant && !reset) ? (4'b0001 << grant_idx) : 4'b0000;
  assign {ready3, ready2, ready1, ready0} = ready_vec;

  always_comb begin
    grant_data = in0;
    case (grant_idx)
      2'd0: grant_data = in0;
      2'd1: grant_data = in1;
      2'd2: grant_data = in2;
      2'd3: grant_data = in3;
      default: grant_data = in0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      out_q   <= '0;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
    end else if (load) begin
      if (any_valid) begin
        state_q <= FULL;
        out_q   <= grant_data;
        sel_q   <= grant_idx;
        last_q  <= grant_idx;
      end else begin
        state_q <= EMPTY;
      end
    end
  end

  assign out = out_q;
  assign sel = sel_q;

endmodule

// File: doc/mux4way_arb.md
MUX4WAY_ARB -- requirements
Module: mux4way_arb

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of every channel and of the output.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: in0, in1, in2, in3  input  WIDTH  channel data.
REQ-005 SHALL have ports: valid0, valid1, valid2, valid3  input  1  channel n offers in_n.
REQ-006 SHALL have ports: ready0, ready1, ready2, ready3  output  1  channel n word taken this cycle.
REQ-007 SHALL have port: out  output  WIDTH  registered merged data.
REQ-008 SHALL have port: out_valid  output  1  out/sel hold a word.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts out this cycle.
REQ-010 SHALL have port: sel  output  2  source channel index of out, binary 0..3.

Function
REQ-011 SHALL be the merging counterpart of the 4-way demultiplexer: four valid/ready sources onto one registered output tagged with sel.
REQ-012 SHALL keep a one-entry output register, state EMPTY (out_valid=0) or FULL (out_valid=1).
REQ-013 SHALL compute load = (state EMPTY) or (out_valid and out_ready).
REQ-014 SHALL, when load and any valid_n is high, grant exactly one channel, chosen round-robin starting at (last+1) mod 4.
REQ-015 SHALL drive ready_n high combinationally only for the granted channel, and only in a cycle where load is high; all other ready lines low.
REQ-016 SHALL, on a clock edge with a grant, capture in_g into out, g into sel, set last=g, and enter FULL.
REQ-017 SHALL, on an edge with load high and no valid_n high, enter EMPTY with out_valid=0; out and sel keep their previous values.
REQ-018 SHALL hold out, sel and out_valid stable while FULL and out_ready=0 (backpressure); last unchanged.
REQ-019 SHALL support accept-and-reload in the same cycle: one word per clock sustained throughput.
REQ-020 SHALL have one-cycle latency: a word granted at edge k appears on out with out_valid=1 after edge k.
REQ-021 SHALL, with all four valid continuously high and out_ready=1, emit sel sequence 0,1,2,3,0,... with no channel skipped.
REQ-022 SHALL skip non-valid channels without idle cycles (e.g. only 1 and 3 valid -> 1,3,1,3).
REQ-023 SHALL not pass a channel's data through when its valid drops before grant; no word is duplicated or lost.
REQ-024 SHALL wrap last from 3 to 0 modulo 4.

Reset
REQ-025 SHALL, while reset=1 (asynchronously, independent of clk): out=0, sel=0, out_valid=0, state EMPTY, last=3, all ready_n=0.
REQ-026 SHALL discard any held word on reset mid-operation; the first grant after reset deasserts goes to the lowest-indexed valid channel at or after 0.
REQ-027 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification
REQ-028 Reset: assert reset mid-FULL with out=8'hA5 -> out=0, sel=0, out_valid=0, ready0..3=0 immediately, before next clk edge.
REQ-029 Single channel: valid2=1, in2=8'h3C, out_ready=1 -> ready2=1 that cycle; next cycle out=8'h3C, sel=2, out_valid=1.
REQ-030 Fairness: valid0..3=1, in_n=8'h10+n, out_ready=1, 8 cycles -> sel 0,1,2,3,0,1,2,3; out 10,11,12,13,10,11,12,13; out_valid=1 every cycle.
REQ-031 Backpressure: FULL with out=8'h11, sel=1, out_ready=0 for 5 cycles, valid0 high -> out/sel unchanged, ready0=0 throughout; on out_ready=1, ready0=1 and next cycle sel=0.
REQ-032 Sparse: only valid1 and valid3 high, out_ready=1 -> sel 1,3,1,3; ready0=ready2=0 always.
REQ-033 Drain: all valid low with out_ready=1 after a word -> out_valid=0 next cycle; out and sel retain last values.
